// File: rtl/data_memory_controller_pkg.sv
// Shared types for the data memory controller: FSM state encoding.
package data_memory_controller_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRespond = 2'd2
    } dmc_state_e;

endpackage

// File: rtl/dmc_timeout_counter.sv
// Watchdog for the ACCESS phase: flags the LIMIT-th consecutive enabled cycle.
module dmc_timeout_counter #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic limit_reached
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count holds the number of cycles already waited, so LIMIT-1 marks the LIMIT-th cycle.
    assign limit_reached = (count_q == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/data_memory_controller.sv
// Single-outstanding bus handshake stage between MEM-stage byte logic and data memory.
// Optional ACCESS watchdog enabled by defining DMC_TIMEOUT_EN.
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memory_read,
    input  logic                  memory_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_memory_write_data,
    input  logic [3:0]            write_mask,
    output logic [31:0]           data_memory_read_data,
    output logic                  memory_stall,
    output logic                  misaligned_store,
    output logic                  access_fault,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    output logic [3:0]            bus_wstrb,
    input  logic                  bus_ack,
    input  logic [31:0]           bus_rdata
);

    localparam logic [ADDR_WIDTH-1:0] WordMask = {{(ADDR_WIDTH - 2){1'b1}}, 2'b00};

    if ((TIMEOUT_CYCLES >> TIMEOUT_WIDTH) != 0) begin : g_cfg_check
        $error("TIMEOUT_WIDTH cannot hold TIMEOUT_CYCLES");
    end

    dmc_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  we_q, we_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  timeout;

`ifdef DMC_TIMEOUT_EN
    logic limit_reached;

    dmc_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk           (clk),
        .reset         (reset),
        .clear         (state_q != StAccess),
        .enable        ((state_q == StAccess) && !bus_ack),
        .limit_reached (limit_reached)
    );

    assign timeout = (state_q == StAccess) && limit_reached;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wstrb_d          = wstrb_q;
        we_d             = we_q;
        rdata_d          = rdata_q;
        memory_stall     = 1'b0;
        misaligned_store = 1'b0;
        access_fault     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Write wins over a simultaneous read, so an empty mask is misaligned either way.
                if (memory_write && (write_mask == 4'b0000)) begin
                    misaligned_store = 1'b1;
                end else if (memory_write || memory_read) begin
                    memory_stall = 1'b1;
                    addr_d       = address & WordMask;
                    we_d         = memory_write;
                    wdata_d      = data_memory_write_data;
                    wstrb_d      = memory_write ? write_mask : 4'b0000;
                    state_d      = StAccess;
                end
            end
            StAccess: begin
                memory_stall = 1'b1;
                if (bus_ack) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = StRespond;
                end else if (timeout) begin
                    access_fault = 1'b1;
                    rdata_d      = '0;
                    state_d      = StRespond;
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Decoded from the state flop so an asynchronous reset drops the request immediately.
    assign bus_req               = (state_q == StAccess);
    assign bus_we                = we_q;
    assign bus_addr              = addr_q;
    assign bus_wdata             = wdata_q;
    assign bus_wstrb             = wstrb_q;
    assign data_memory_read_data = rdata_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed, table-driven bench for data_memory_controller.
module tb_data_memory_controller;

    logic        clk;
    logic        reset;
    logic        memory_read;
    logic        memory_write;
    logic [31:0] address;
    logic [31:0] data_memory_write_data;
    logic [3:0]  write_mask;
    logic [31:0] data_memory_read_data;
    logic        memory_stall;
    logic        misaligned_store;
    logic        access_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    data_memory_controller #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .memory_read            (memory_read),
        .memory_write           (memory_write),
        .address                (address),
        .data_memory_write_data (data_memory_write_data),
        .write_mask             (write_mask),
        .data_memory_read_data  (data_memory_read_data),
        .memory_stall           (memory_stall),
        .misaligned_store       (misaligned_store),
        .access_fault           (access_fault),
        .bus_req                (bus_req),
        .bus_we                 (bus_we),
        .bus_addr               (bus_addr),
        .bus_wdata              (bus_wdata),
        .bus_wstrb              (bus_wstrb),
        .bus_ack                (bus_ack),
        .bus_rdata              (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        int          ack_at;
        logic        mis;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        int          exp_stalls;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        int  stalls = 0;
        int  acc    = 0;
        bit  done   = 0;
        string tag  = $sformatf("v%0d", idx);
        @(negedge clk);
        memory_read            = v.rd;
        memory_write           = v.wr;
        address                = v.addr;
        data_memory_write_data = v.wdata;
        write_mask             = v.mask;
        bus_ack                = 1'b0;
        bus_rdata              = v.rdata;
        #1;
        if (v.mis) begin
            check({tag, " misaligned"}, 32'(misaligned_store), 32'd1);
            check({tag, " mis_stall"}, 32'(memory_stall), 32'd0);
            check({tag, " mis_req"}, 32'(bus_req), 32'd0);
            @(negedge clk);
            memory_read  = 1'b0;
            memory_write = 1'b0;
            #1;
            check({tag, " mis_stays_idle"}, 32'(bus_req), 32'd0);
            check({tag, " mis_pulse_end"}, 32'(misaligned_store), 32'd0);
            return;
        end
        if (memory_stall) stalls++;
        while (!done && acc < 64) begin
            @(negedge clk);
            acc++;
            bus_ack = (acc == v.ack_at);
            #1;
            if (memory_stall) stalls++;
            if (acc == 1) begin
                check({tag, " bus_req"}, 32'(bus_req), 32'd1);
                check({tag, " bus_addr"}, bus_addr, v.exp_addr);
                check({tag, " bus_we"}, 32'(bus_we), 32'(v.exp_we));
                check({tag, " bus_wstrb"}, 32'(bus_wstrb), 32'(v.exp_wstrb));
                if (v.wr) check({tag, " bus_wdata"}, bus_wdata, v.wdata);
            end
            if (bus_ack) done = 1;
        end
        if (!done) check({tag, " ack_bound"}, 32'd0, 32'd1);
        @(negedge clk);
        bus_ack      = 1'b0;
        memory_read  = 1'b0;
        memory_write = 1'b0;
        #1;
        check({tag, " release_stall"}, 32'(memory_stall), 32'd0);
        check({tag, " release_req"}, 32'(bus_req), 32'd0);
        check({tag, " read_data"}, data_memory_read_data, v.exp_rd);
        check({tag, " stall_cycles"}, 32'(stalls), 32'(v.exp_stalls));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        rd  wr  addr          wdata         mask     rdata         ack mis exp_addr     we  wstrb  st exp_rd
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h1111_1111, 3, 1'b0,
                    32'h0000_0100, 1'b1, 4'b1111, 4, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0203, 32'h0000_0000, 4'b0000, 32'hCAFE_BEBE, 1, 1'b0,
                    32'h0000_0200, 1'b0, 4'b0000, 2, 32'hCAFE_BEBE};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0302, 32'h7777_7777, 4'b0000, 32'h0000_0000, 1, 1'b1,
                    32'h0, 1'b0, 4'b0000, 0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0404, 32'h1234_5678, 4'b0011, 32'h5555_5555, 2, 1'b0,
                    32'h0000_0404, 1'b1, 4'b0011, 3, 32'hCAFE_BEBE};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0007, 32'hABAB_ABAB, 4'b1000, 32'h2222_2222, 1, 1'b0,
                    32'h0000_0004, 1'b1, 4'b1000, 2, 32'hCAFE_BEBE};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0000, 4'b0000, 32'h0BAD_F00D, 4, 1'b0,
                    32'hFFFF_FFFC, 1'b0, 4'b0000, 5, 32'h0BAD_F00D};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0501, 32'h3333_3333, 4'b0000, 32'h0000_0000, 1, 1'b1,
                    32'h0, 1'b0, 4'b0000, 0, 32'h0};

        reset                  = 1'b1;
        memory_read            = 1'b0;
        memory_write           = 1'b0;
        address                = '0;
        data_memory_write_data = '0;
        write_mask             = '0;
        bus_ack                = 1'b0;
        bus_rdata              = '0;
        #12;
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset stall", 32'(memory_stall), 32'd0);
        check("reset read_data", data_memory_read_data, 32'd0);
        check("reset bus_addr", bus_addr, 32'd0);
        check("reset bus_we", 32'(bus_we), 32'd0);
        check("reset fault", 32'(access_fault), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_txn(i, vecs[i]);
        end

        // bus_ack while idle must be ignored
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        #1;
        check("idle_ack bus_req", 32'(bus_req), 32'd0);
        check("idle_ack stall", 32'(memory_stall), 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("idle_ack stays_idle", 32'(bus_req), 32'd0);
        check("idle_ack read_data", data_memory_read_data, 32'h0BAD_F00D);

        // asynchronous reset in the middle of ACCESS
        @(negedge clk);
        memory_read = 1'b1;
        address     = 32'h0000_0080;
        #1;
        check("rst_seq idle_stall", 32'(memory_stall), 32'd1);
        @(negedge clk);
        #1;
        check("rst_seq req_before", 32'(bus_req), 32'd1);
        #1;
        reset       = 1'b1;
        memory_read = 1'b0;
        #1;
        check("rst_seq req_drop", 32'(bus_req), 32'd0);
        check("rst_seq bus_addr", bus_addr, 32'd0);
        check("rst_seq read_data", data_memory_read_data, 32'd0);
        check("rst_seq stall", 32'(memory_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_seq idle_after", 32'(bus_req), 32'd0);
        do_txn(10, vecs[1]);

`ifdef DMC_TIMEOUT_EN
        // no ack: fault on the 4th ACCESS cycle, read data cleared
        @(negedge clk);
        memory_read = 1'b1;
        address     = 32'h0000_0040;
        for (int acc = 1; acc <= 4; acc++) begin
            @(negedge clk);
            #1;
            check($sformatf("tmo fault_c%0d", acc), 32'(access_fault), 32'(acc == 4));
        end
        @(negedge clk);
        memory_read = 1'b0;
        #1;
        check("tmo respond_req", 32'(bus_req), 32'd0);
        check("tmo respond_stall", 32'(memory_stall), 32'd0);
        check("tmo read_data", data_memory_read_data, 32'd0);
        check("tmo fault_pulse_end", 32'(access_fault), 32'd0);

        // ack on the limit cycle wins
        @(negedge clk);
        memory_read = 1'b1;
        bus_rdata   = 32'h600D_CAFE;
        for (int acc = 1; acc <= 4; acc++) begin
            @(negedge clk);
            bus_ack = (acc == 4);
            #1;
            check($sformatf("tmo_ack fault_c%0d", acc), 32'(access_fault), 32'd0);
        end
        @(negedge clk);
        bus_ack     = 1'b0;
        memory_read = 1'b0;
        #1;
        check("tmo_ack read_data", data_memory_read_data, 32'h600D_CAFE);
        check("tmo_ack req", 32'(bus_req), 32'd0);
`else
        // without the watchdog ACCESS waits indefinitely
        begin
            bit fault_seen = 0;
            bit req_lost   = 0;
            @(negedge clk);
            memory_read = 1'b1;
            address     = 32'h0000_0040;
            bus_rdata   = 32'h600D_CAFE;
            for (int acc = 1; acc <= 20; acc++) begin
                @(negedge clk);
                #1;
                if (access_fault) fault_seen = 1;
                if (!bus_req) req_lost = 1;
            end
            check("noto fault_seen", 32'(fault_seen), 32'd0);
            check("noto req_lost", 32'(req_lost), 32'd0);
            @(negedge clk);
            bus_ack = 1'b1;
            @(negedge clk);
            bus_ack     = 1'b0;
            memory_read = 1'b0;
            #1;
            check("noto read_data", data_memory_read_data, 32'h600D_CAFE);
            check("noto stall", 32'(memory_stall), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
